// File: rtl/if_pkg.sv
// Shared widths, NOP encoding and the packed queue entry layout for the
// fetch/decode buffering stage.
package if_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  // Entry is {instn, nextpc, pc}; pc occupies the least significant bits.
  localparam int ENTRY_W     = INSTR_W + 2 * ADDR_W;
  localparam int PC_LSB      = 0;
  localparam int NEXTPC_LSB  = ADDR_W;
  localparam int INSTN_LSB   = 2 * ADDR_W;

  typedef struct packed {
    logic [INSTR_W-1:0] instn;
    logic [ADDR_W-1:0]  nextpc;
    logic [ADDR_W-1:0]  pc;
  } entry_t;

  function automatic entry_t make_entry(input logic [INSTR_W-1:0] instn,
                                        input logic [ADDR_W-1:0]  nextpc,
                                        input logic [ADDR_W-1:0]  pc);
    entry_t e;
    e.instn  = instn;
    e.nextpc = nextpc;
    e.pc     = pc;
    return e;
  endfunction

endpackage

// File: rtl/if_id_queue_ram.sv
// Storage for the fetch/decode queue: one clocked write port, one
// asynchronous read port, no reset on the array.
module if_id_queue_ram #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2,
  parameter int W     = 96
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] wr_addr,
  input  logic [W-1:0]     wr_data,
  input  logic [PTR_W-1:0] rd_addr,
  output logic [W-1:0]     rd_data
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/if_id_queue.sv
// Circular queue between instruction fetch and decode: valid/ready on both
// sides, occupancy tracked by count, flush discards everything queued.
module if_id_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2,
  parameter logic [31:0] NOP_INSTR = if_pkg::NOP_INSTR
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  input  logic [if_pkg::INSTR_W-1:0]  inp_instn,
  input  logic [if_pkg::ADDR_W-1:0]   nextpc,
  input  logic [if_pkg::ADDR_W-1:0]   pc_to_branch,
  output logic                        in_ready,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [if_pkg::INSTR_W-1:0]  out_instn,
  output logic [if_pkg::ADDR_W-1:0]   out_nextpc,
  output logic [if_pkg::ADDR_W-1:0]   out_pc,
  input  logic                        flush,
  output logic [PTR_W:0]              count
);

  import if_pkg::*;

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;
  entry_t           wr_entry;
  entry_t           head;

  // Handshake flags come only from registered occupancy, so in_ready never
  // depends combinationally on out_ready.
  assign in_ready  = (count != FULL_COUNT);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  assign wr_entry = make_entry(inp_instn, nextpc, pc_to_branch);

  if_id_queue_ram #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .W     (ENTRY_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data (wr_entry),
    .rd_addr (rd_ptr),
    .rd_data (head)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Stale array contents are never exposed: an empty queue shows a NOP.
  always_comb begin
    out_instn  = NOP_INSTR;
    out_nextpc = '0;
    out_pc     = '0;
    if (out_valid) begin
      out_instn  = head.instn;
      out_nextpc = head.nextpc;
      out_pc     = head.pc;
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: a queue-based reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_if_id_queue;

  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic [31:0] instn;
    logic [31:0] nextpc;
    logic [31:0] pc;
  } model_entry_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] inp_instn;
  logic [31:0] nextpc;
  logic [31:0] pc_to_branch;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instn;
  logic [31:0] out_nextpc;
  logic [31:0] out_pc;
  logic        flush;
  logic [2:0]  count;

  int n_checks = 0;
  int n_pass   = 0;

  model_entry_t model_q[$];

  if_id_queue dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .inp_instn    (inp_instn),
    .nextpc       (nextpc),
    .pc_to_branch (pc_to_branch),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_instn    (out_instn),
    .out_nextpc   (out_nextpc),
    .out_pc       (out_pc),
    .flush        (flush),
    .count        (count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual === expected) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs, then return just after the edge that used them.
  task automatic applyStimulus(input logic v, input logic [31:0] instn,
                               input logic [31:0] pc, input logic ordy,
                               input logic fl);
    in_valid     = v;
    inp_instn    = instn;
    pc_to_branch = pc;
    nextpc       = pc + 32'd4;
    out_ready    = ordy;
    flush        = fl;
    @(posedge clk);
    #2;
  endtask

  // Reference model: a plain queue following the push/pop/flush rules.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      model_q.delete();
    end else if (flush) begin
      model_q.delete();
    end else begin
      automatic bit do_pop  = (model_q.size() != 0) && out_ready;
      automatic bit do_push = in_valid && (model_q.size() != DEPTH);
      automatic model_entry_t e;
      e.instn  = inp_instn;
      e.nextpc = nextpc;
      e.pc     = pc_to_branch;
      if (do_pop) void'(model_q.pop_front());
      if (do_push) model_q.push_back(e);
    end
  end

  // Every cycle, compare all outputs with the model on the falling edge.
  always @(negedge clk) begin
    automatic int sz = model_q.size();
    checkOutput("count",     {29'd0, count},     sz);
    checkOutput("out_valid", {31'd0, out_valid}, (sz != 0) ? 32'd1 : 32'd0);
    checkOutput("in_ready",  {31'd0, in_ready},  (sz != DEPTH) ? 32'd1 : 32'd0);
    checkOutput("out_instn", out_instn,  (sz != 0) ? model_q[0].instn  : NOP);
    checkOutput("out_nextpc", out_nextpc, (sz != 0) ? model_q[0].nextpc : 32'd0);
    checkOutput("out_pc",    out_pc,     (sz != 0) ? model_q[0].pc     : 32'd0);
  end

  initial begin
    logic [31:0] seq [8];
    reset = 1'b1;
    in_valid = 1'b0; inp_instn = '0; nextpc = '0; pc_to_branch = '0;
    out_ready = 1'b0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;

    // Idle after reset.
    for (int i = 0; i < 10; i++) applyStimulus(0, 32'd0, 32'd0, 0, 0);
    checkOutput("idle_instn", out_instn, 32'h0000_0013);
    checkOutput("idle_count", {29'd0, count}, 32'd0);
    checkOutput("idle_in_ready", {31'd0, in_ready}, 32'd1);

    // Single push with decode ready: visible one edge later, then consumed.
    applyStimulus(1, 32'h00A00093, 32'h4, 1, 0);
    checkOutput("single_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("single_pc", out_pc, 32'h4);
    checkOutput("single_nextpc", out_nextpc, 32'h8);
    checkOutput("single_instn", out_instn, 32'h00A00093);
    applyStimulus(0, 32'd0, 32'd0, 1, 0);
    checkOutput("single_drained", {29'd0, count}, 32'd0);

    // Fill while decode stalls; fifth push refused.
    for (int i = 0; i < 4; i++) applyStimulus(1, $urandom, 32'(4 * i), 0, 0);
    checkOutput("full_count", {29'd0, count}, 32'd4);
    checkOutput("full_in_ready", {31'd0, in_ready}, 32'd0);
    applyStimulus(1, $urandom, 32'd16, 0, 0);
    checkOutput("full_refuse_count", {29'd0, count}, 32'd4);
    checkOutput("full_hold_pc", out_pc, 32'd0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("drain_pc", out_pc, 32'(4 * i));
      applyStimulus(0, 32'd0, 32'd0, 1, 0);
    end
    checkOutput("drain_empty", {29'd0, count}, 32'd0);

    // Steady push+pop at occupancy 2, pointers wrap.
    seq = '{32'd8, 32'd12, 32'd16, 32'd20, 32'd24, 32'd28, 32'd32, 32'd36};
    applyStimulus(1, $urandom, seq[0], 0, 0);
    applyStimulus(1, $urandom, seq[1], 0, 0);
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1, $urandom, seq[k + 2], 1, 0);
      checkOutput("stream_count", {29'd0, count}, 32'd2);
      checkOutput("stream_pc", out_pc, seq[k + 1]);
    end

    // Flush at occupancy 3 beats a simultaneous push and pop.
    applyStimulus(1, $urandom, 32'h40, 0, 0);
    checkOutput("preflush_count", {29'd0, count}, 32'd3);
    applyStimulus(1, 32'hDEADBEEF, 32'h44, 1, 1);
    checkOutput("flush_count", {29'd0, count}, 32'd0);
    checkOutput("flush_valid", {31'd0, out_valid}, 32'd0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 32'd0, 32'd0, 1, 0);
    checkOutput("flush_no_ghost", out_instn, NOP);

    // Asynchronous reset in the middle of a cycle.
    applyStimulus(1, $urandom, 32'h50, 0, 0);
    applyStimulus(1, $urandom, 32'h54, 0, 0);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    checkOutput("async_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("async_count", {29'd0, count}, 32'd0);
    #1 reset = 1'b0;
    @(posedge clk);
    #2;
    applyStimulus(1, 32'h11111111, 32'h60, 0, 0);
    checkOutput("post_reset_pc", out_pc, 32'h60);
    applyStimulus(1, 32'h22222222, 32'h64, 0, 0);
    checkOutput("post_reset_hold_pc", out_pc, 32'h60);
    checkOutput("post_reset_instn", out_instn, 32'h11111111);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0), $urandom,
                    {$urandom_range(0, 1023), 2'b00},
                    1'($urandom_range(0, 2) == 0),
                    1'($urandom_range(0, 15) == 0));
    end

    applyStimulus(0, 32'd0, 32'd0, 0, 0);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
